// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and helpers for the single-port SRAM arbiter.
//   src_e          : which requester owns an in-flight response
//   rsp_t          : response-tracking record (valid, source, write, error)
//   addr_in_window : legal-address check used by both request ports
// -----------------------------------------------------------------------------
package sram_arb_pkg;

  typedef enum logic {
    SrcData  = 1'b0,
    SrcInstr = 1'b1
  } src_e;

  typedef struct packed {
    logic vld;
    src_e src;
    logic we;
    logic err;
  } rsp_t;

  // An address is legal when every bit outside the mask matches the base.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] start,
                                          input logic [31:0] mask);
    return (addr & ~mask) == start;
  endfunction

endpackage

// File: rtl/sram_arb_policy.sv
// -----------------------------------------------------------------------------
// sram_arb_policy
// Fixed data-priority arbitration with a bounded starvation guard for fetch.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   d_req_i, i_req_i   : data / fetch requests
//   d_gnt_o, i_gnt_o   : one-hot combinational grants (both 0 in reset)
// -----------------------------------------------------------------------------
module sram_arb_policy
  import sram_arb_pkg::*;
#(
  parameter int MaxStall = 4,
  localparam int SW = $clog2(MaxStall + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_req_i,
  input  logic i_req_i,
  output logic d_gnt_o,
  output logic i_gnt_o
);

  localparam logic [SW-1:0] StallMax = SW'(MaxStall);

  // Consecutive conflicts fetch has lost; fetch wins once it reaches StallMax.
  logic [SW-1:0] stall_q, stall_d;

  // NOTE: every output of this block is given a default before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    d_gnt_o = 1'b0;
    i_gnt_o = 1'b0;
    stall_d = stall_q;

    if (!rst_i) begin
      if (d_req_i && i_req_i) begin
        if (stall_q == StallMax) i_gnt_o = 1'b1;
        else                     d_gnt_o = 1'b1;
      end else if (d_req_i) begin
        d_gnt_o = 1'b1;
      end else if (i_req_i) begin
        i_gnt_o = 1'b1;
      end
    end

    if (!i_req_i || i_gnt_o)     stall_d = '0;
    else if (stall_q != StallMax) stall_d = stall_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
// Shares one single-port SRAM (1-cycle read latency) between the Ibex data
// and instruction-fetch ports using the req/gnt/rvalid/err protocol.
// Out-of-window accesses are granted but never reach the RAM; they answer
// with err=1 one cycle later.
// Ports:
//   clk_i, rst_i                           : clock, synchronous active-high reset
//   d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i : data request
//   d_gnt_o/d_rvalid_o/d_rdata_o/d_err_o   : data response
//   i_req_i/i_addr_i                       : fetch request (read-only)
//   i_gnt_o/i_rvalid_o/i_rdata_o/i_err_o   : fetch response
//   ram_req_o/ram_we_o/ram_be_o/ram_addr_o/ram_wdata_o : SRAM request
//   ram_rdata_i                            : SRAM read data, cycle after ram_req_o
// -----------------------------------------------------------------------------
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int          Depth    = 16384,
  parameter logic [31:0] MemStart = 32'h0000_0000,
  parameter logic [31:0] MemMask  = 32'h0000_FFFF,
  parameter int          MaxStall = 4,
  localparam int AW = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [3:0]    d_be_i,
  input  logic [31:0]   d_addr_i,
  input  logic [31:0]   d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [31:0]   d_rdata_o,
  output logic          d_err_o,

  input  logic          i_req_i,
  input  logic [31:0]   i_addr_i,
  output logic          i_gnt_o,
  output logic          i_rvalid_o,
  output logic [31:0]   i_rdata_o,
  output logic          i_err_o,

  output logic          ram_req_o,
  output logic          ram_we_o,
  output logic [3:0]    ram_be_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [31:0]   ram_wdata_o,
  input  logic [31:0]   ram_rdata_i
);

  logic d_legal, i_legal;
  rsp_t rsp_q, rsp_d;

  sram_arb_policy #(
    .MaxStall (MaxStall)
  ) u_policy (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_req_i (d_req_i),
    .i_req_i (i_req_i),
    .d_gnt_o (d_gnt_o),
    .i_gnt_o (i_gnt_o)
  );

  assign d_legal = addr_in_window(d_addr_i, MemStart, MemMask);
  assign i_legal = addr_in_window(i_addr_i, MemStart, MemMask);

  // Route the winner to the RAM and record what its response must look like.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = '0;
    ram_wdata_o = 32'h0;
    rsp_d       = '0;

    if (d_gnt_o) begin
      ram_req_o   = d_legal;
      ram_we_o    = d_we_i;
      ram_be_o    = d_be_i;
      ram_addr_o  = d_addr_i[AW+1:2];
      ram_wdata_o = d_wdata_i;
      rsp_d       = '{vld: 1'b1, src: SrcData, we: d_we_i, err: !d_legal};
    end else if (i_gnt_o) begin
      ram_req_o   = i_legal;
      ram_be_o    = 4'hF;
      ram_addr_o  = i_addr_i[AW+1:2];
      rsp_d       = '{vld: 1'b1, src: SrcInstr, we: 1'b0, err: !i_legal};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rsp_q <= '0;
    else       rsp_q <= rsp_d;
  end

  // Responses are suppressed while reset is held so an access granted just
  // before reset never produces an rvalid.
  always_comb begin
    d_rvalid_o = rsp_q.vld && (rsp_q.src == SrcData)  && !rst_i;
    i_rvalid_o = rsp_q.vld && (rsp_q.src == SrcInstr) && !rst_i;
    d_err_o    = d_rvalid_o && rsp_q.err;
    i_err_o    = i_rvalid_o && rsp_q.err;
    d_rdata_o  = (d_rvalid_o && !rsp_q.we && !rsp_q.err) ? ram_rdata_i : 32'h0;
    i_rdata_o  = (i_rvalid_o && !rsp_q.err) ? ram_rdata_i : 32'h0;
  end

endmodule
